mips_decode_exec: RTL and testbench

MIPS_DECODE_EXEC -- requirements
Module: mips_decode_exec

---
 rtl/mips_decode_exec_if.sv | 29 ++
 rtl/mips_decode_exec.sv | 189 ++++++++++++++++++
 tb/tb_mips_decode_exec.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mips_decode_exec_if.sv
// Instruction/operand bus into the decode+execute stage and its registered
// control/result outputs.
interface mips_decode_exec_if #(parameter int XLEN = 32);
  logic [31:0]     inst;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [3:0]      alu_ctl;
  logic [1:0]      alu_src;
  logic [2:0]      branch;
  logic [1:0]      jump;
  logic            reg_dst, mem_to_reg, reg_write, mem_read, mem_write;
  logic            is_LW_SW, jr, do_extend, take_branch, halted, illegal;

  modport master (
    output inst, rs_data, rt_data,
    input  alu_result, zero, alu_ctl, alu_src, branch, jump, reg_dst,
           mem_to_reg, reg_write, mem_read, mem_write, is_LW_SW, jr,
           do_extend, take_branch, halted, illegal
  );

  modport slave (
    input  inst, rs_data, rt_data,
    output alu_result, zero, alu_ctl, alu_src, branch, jump, reg_dst,
           mem_to_reg, reg_write, mem_read, mem_write, is_LW_SW, jr,
           do_extend, take_branch, halted, illegal
  );
endinterface

// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS decode + ALU + branch resolve; every output registered,
// one instruction per cycle, no handshake.
module mips_decode_exec #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst_b,
  mips_decode_exec_if.slave bus
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3,
                         XOR = 4'd4, NOR = 4'd5, SLT = 4'd6, SLTU = 4'd7,
                         SLL = 4'd8, SRL = 4'd9, SRA = 4'd10, LUI = 4'd11;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic [1:0] alu_src;
    logic [2:0] branch;
    logic [1:0] jump;
    logic       reg_dst, mem_to_reg, reg_write, mem_read, mem_write;
    logic       is_lw_sw, jr, do_extend, halted, illegal;
  } ctl_t;

  logic [5:0]      opcode, funct;
  logic [4:0]      rt_f, shamt;
  logic [15:0]     imm;
  logic [XLEN-1:0] ext, a, b, res;
  logic            take;
  ctl_t            c;

  assign opcode = bus.inst[31:26];
  assign rt_f   = bus.inst[20:16];
  assign shamt  = bus.inst[10:6];
  assign funct  = bus.inst[5:0];
  assign imm    = bus.inst[15:0];

  // rs/rd register-number fields are resolved by the register file upstream
  logic unused_fields;
  assign unused_fields = &{1'b0, bus.inst[25:21]};

  always_comb begin
    c = '0;
    case (opcode)
      6'h00: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: c.alu_ctl = ADD;
          6'h22, 6'h23: c.alu_ctl = SUB;
          6'h24: c.alu_ctl = AND;
          6'h25: c.alu_ctl = OR;
          6'h26: c.alu_ctl = XOR;
          6'h27: c.alu_ctl = NOR;
          6'h2A: c.alu_ctl = SLT;
          6'h2B: c.alu_ctl = SLTU;
          6'h00: begin c.alu_ctl = SLL; c.alu_src = 2'b01; end
          6'h02: begin c.alu_ctl = SRL; c.alu_src = 2'b01; end
          6'h03: begin c.alu_ctl = SRA; c.alu_src = 2'b01; end
          6'h04: c.alu_ctl = SLL;
          6'h06: c.alu_ctl = SRL;
          6'h07: c.alu_ctl = SRA;
          6'h08: begin c = '0; c.jr = 1'b1; end
          6'h0C: begin c = '0; c.halted = 1'b1; end
          default: begin c = '0; c.illegal = 1'b1; end
        endcase
      end
      6'h01: begin
        c.alu_ctl   = SUB;
        c.do_extend = 1'b1;
        case (rt_f)
          5'd0: c.branch = 3'b101;
          5'd1: c.branch = 3'b110;
          default: begin c = '0; c.illegal = 1'b1; end
        endcase
      end
      6'h02: c.jump = 2'b01;
      6'h03: begin c.jump = 2'b10; c.reg_write = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        c.alu_ctl   = SUB;
        c.do_extend = 1'b1;
        c.branch    = 3'(opcode[2:0] - 3'd3);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.alu_src   = 2'b10;
        c.reg_write = 1'b1;
        c.do_extend = (opcode[3:2] == 2'b10);
        case (opcode[2:0])
          3'd2:    c.alu_ctl = SLT;
          3'd3:    c.alu_ctl = SLTU;
          3'd4:    c.alu_ctl = AND;
          3'd5:    c.alu_ctl = OR;
          3'd6:    c.alu_ctl = XOR;
          3'd7:    c.alu_ctl = LUI;
          default: c.alu_ctl = ADD;
        endcase
      end
      6'h20, 6'h23: begin
        c.alu_src    = 2'b10;
        c.do_extend  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.is_lw_sw   = (opcode == 6'h20);
      end
      6'h28, 6'h2B: begin
        c.alu_src   = 2'b10;
        c.do_extend = 1'b1;
        c.mem_write = 1'b1;
        c.is_lw_sw  = (opcode == 6'h28);
      end
      default: c.illegal = 1'b1;
    endcase
  end

  assign ext = c.do_extend ? {{(XLEN-16){imm[15]}}, imm} : {{(XLEN-16){1'b0}}, imm};
  assign a   = c.alu_src[0] ? {{(XLEN-5){1'b0}}, shamt} : bus.rs_data;
  assign b   = c.alu_src[1] ? ext : bus.rt_data;

  always_comb begin
    res = a + b;
    case (c.alu_ctl)
      SUB:  res = a - b;
      AND:  res = a & b;
      OR:   res = a | b;
      XOR:  res = a ^ b;
      NOR:  res = ~(a | b);
      SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      SLL:  res = b << a[4:0];
      SRL:  res = b >> a[4:0];
      SRA:  res = $signed(b) >>> a[4:0];
      LUI:  res = b << 16;
      default: ;
    endcase
  end

  // branch conditions look at raw register values, not the ALU operands
  always_comb begin
    take = 1'b0;
    case (c.branch)
      3'b001: take = (bus.rs_data == bus.rt_data);
      3'b010: take = (bus.rs_data != bus.rt_data);
      3'b011: take = ($signed(bus.rs_data) <= 0);
      3'b100: take = ($signed(bus.rs_data) > 0);
      3'b101: take = ($signed(bus.rs_data) < 0);
      3'b110: take = ($signed(bus.rs_data) >= 0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      bus.alu_result  <= '0;
      bus.zero        <= 1'b0;
      bus.alu_ctl     <= '0;
      bus.alu_src     <= '0;
      bus.branch      <= '0;
      bus.jump        <= '0;
      bus.reg_dst     <= 1'b0;
      bus.mem_to_reg  <= 1'b0;
      bus.reg_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.is_LW_SW    <= 1'b0;
      bus.jr          <= 1'b0;
      bus.do_extend   <= 1'b0;
      bus.take_branch <= 1'b0;
      bus.halted      <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.alu_result  <= res;
      bus.zero        <= (res == '0);
      bus.alu_ctl     <= c.alu_ctl;
      bus.alu_src     <= c.alu_src;
      bus.branch      <= c.branch;
      bus.jump        <= c.jump;
      bus.reg_dst     <= c.reg_dst;
      bus.mem_to_reg  <= c.mem_to_reg;
      bus.reg_write   <= c.reg_write;
      bus.mem_read    <= c.mem_read;
      bus.mem_write   <= c.mem_write;
      bus.is_LW_SW    <= c.is_lw_sw;
      bus.jr          <= c.jr;
      bus.do_extend   <= c.do_extend;
      bus.take_branch <= take;
      bus.halted      <= c.halted;
      bus.illegal     <= c.illegal;
    end
  end
endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboarded random bench: driver pushes reference-model expectations, a
// monitor pops one per clock and compares against the registered outputs.
module tb_mips_decode_exec;
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [3:0]  ctl;
    logic [1:0]  src;
    logic [2:0]  br;
    logic [1:0]  jmp;
    logic rd, m2r, rw, mr, mw, bt, jr, dx, tk, hl, il;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  mips_decode_exec_if #(.XLEN(32)) bus ();
  mips_decode_exec #(.XLEN(32)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0] op, f;
    logic [4:0] sh;
    logic [31:0] sx, zx;
    e = '0;
    op = i[31:26]; f = i[5:0]; sh = i[10:6];
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'h0, i[15:0]};
    e.res = rs + rt;
    case (op)
      6'h00: begin
        e.rd = 1'b1; e.rw = 1'b1;
        case (f)
          6'h20, 6'h21: e.res = rs + rt;
          6'h22, 6'h23: begin e.ctl = 1; e.res = rs - rt; end
          6'h24: begin e.ctl = 2; e.res = rs & rt; end
          6'h25: begin e.ctl = 3; e.res = rs | rt; end
          6'h26: begin e.ctl = 4; e.res = rs ^ rt; end
          6'h27: begin e.ctl = 5; e.res = ~(rs | rt); end
          6'h2A: begin e.ctl = 6; e.res = {31'b0, $signed(rs) < $signed(rt)}; end
          6'h2B: begin e.ctl = 7; e.res = {31'b0, rs < rt}; end
          6'h00: begin e.ctl = 8;  e.src = 1; e.res = rt << sh; end
          6'h02: begin e.ctl = 9;  e.src = 1; e.res = rt >> sh; end
          6'h03: begin e.ctl = 10; e.src = 1; e.res = $signed(rt) >>> sh; end
          6'h04: begin e.ctl = 8;  e.res = rt << rs[4:0]; end
          6'h06: begin e.ctl = 9;  e.res = rt >> rs[4:0]; end
          6'h07: begin e.ctl = 10; e.res = $signed(rt) >>> rs[4:0]; end
          6'h08: begin e.rd = 0; e.rw = 0; e.jr = 1; end
          6'h0C: begin e.rd = 0; e.rw = 0; e.hl = 1; end
          default: begin e.rd = 0; e.rw = 0; e.il = 1; end
        endcase
      end
      6'h01: begin
        if (i[20:16] == 5'd0) begin
          e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b101; e.tk = $signed(rs) < 0;
        end else if (i[20:16] == 5'd1) begin
          e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b110; e.tk = $signed(rs) >= 0;
        end else e.il = 1;
      end
      6'h02: e.jmp = 2'b01;
      6'h03: begin e.jmp = 2'b10; e.rw = 1; end
      6'h04: begin e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b001; e.tk = (rs == rt); end
      6'h05: begin e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b010; e.tk = (rs != rt); end
      6'h06: begin e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b011; e.tk = $signed(rs) <= 0; end
      6'h07: begin e.ctl = 1; e.dx = 1; e.res = rs - rt; e.br = 3'b100; e.tk = $signed(rs) > 0; end
      6'h08, 6'h09: begin e.src = 2; e.rw = 1; e.dx = 1; e.res = rs + sx; end
      6'h0A: begin e.src = 2; e.rw = 1; e.dx = 1; e.ctl = 6; e.res = {31'b0, $signed(rs) < $signed(sx)}; end
      6'h0B: begin e.src = 2; e.rw = 1; e.dx = 1; e.ctl = 7; e.res = {31'b0, rs < sx}; end
      6'h0C: begin e.src = 2; e.rw = 1; e.ctl = 2; e.res = rs & zx; end
      6'h0D: begin e.src = 2; e.rw = 1; e.ctl = 3; e.res = rs | zx; end
      6'h0E: begin e.src = 2; e.rw = 1; e.ctl = 4; e.res = rs ^ zx; end
      6'h0F: begin e.src = 2; e.rw = 1; e.ctl = 11; e.res = {i[15:0], 16'h0}; end
      6'h20, 6'h23: begin
        e.src = 2; e.dx = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.bt = (op == 6'h20); e.res = rs + sx;
      end
      6'h28, 6'h2B: begin
        e.src = 2; e.dx = 1; e.mw = 1; e.bt = (op == 6'h28); e.res = rs + sx;
      end
      default: e.il = 1;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    rst_b = r;
    bus.inst = i; bus.rs_data = a; bus.rt_data = b;
    if (!r) sb.push_back('0);
    else sb.push_back(model(i, a, b));
  endtask

  // monitor: one expectation is retired per rising edge
  initial begin
    exp_t e, act, ec, ac;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = '{res: bus.alu_result, zero: bus.zero, ctl: bus.alu_ctl, src: bus.alu_src,
                br: bus.branch, jmp: bus.jump, rd: bus.reg_dst, m2r: bus.mem_to_reg,
                rw: bus.reg_write, mr: bus.mem_read, mw: bus.mem_write, bt: bus.is_LW_SW,
                jr: bus.jr, dx: bus.do_extend, tk: bus.take_branch, hl: bus.halted,
                il: bus.illegal};
        total++;
        if (act.res !== e.res || act.zero !== e.zero) begin
          bad++;
          $display("FAIL result t=%0t got=%h/%b exp=%h/%b", $time, act.res, act.zero, e.res, e.zero);
        end
        ec = e; ac = act;
        ec.res = '0; ec.zero = 1'b0; ac.res = '0; ac.zero = 1'b0;
        total++;
        if (ac !== ec) begin
          bad++;
          $display("FAIL control t=%0t got=%h exp=%h", $time, ac, ec);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  logic [5:0] ops [24] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B, 6'h3F, 6'h11};
  logic [5:0] fns [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                           6'h08, 6'h0C, 6'h3F};

  task automatic rand_op(input logic r);
    logic [31:0] i, a, b;
    i = $urandom;
    i[31:26] = ops[$urandom_range(0, 23)];
    if (i[31:26] == 6'h00 && $urandom_range(0, 7) != 0) i[5:0] = fns[$urandom_range(0, 18)];
    if (i[31:26] == 6'h01) i[20:16] = 5'($urandom_range(0, 3));
    a = $urandom; b = $urandom;
    case ($urandom_range(0, 4))
      0: b = a;
      1: a = 32'h0;
      2: a = 32'h8000_0000;
      3: a = 32'hFFFF_FFFF;
      default: ;
    endcase
    drive(r, i, a, b);
  endtask

  initial begin
    bus.inst = '0; bus.rs_data = '0; bus.rt_data = '0;
    // syscall held in reset must not surface until reset releases
    drive(1'b0, 32'h0000_000C, 0, 0);
    drive(1'b0, 32'h0000_000C, 0, 0);
    drive(1'b1, 32'h0000_000C, 0, 0);
    drive(1'b1, 32'h0022_1820, 5, 7);
    drive(1'b1, 32'h0022_1822, 9, 9);
    drive(1'b1, 32'h0002_1903, 0, 32'h8000_0000);
    drive(1'b1, 32'h3C01_1234, 3, 3);
    drive(1'b1, 32'h2001_FFFF, 0, 0);
    drive(1'b1, 32'h3001_FFFF, 32'hF0F0_F0F0, 0);
    drive(1'b1, 32'h1022_0003, 4, 4);
    drive(1'b1, 32'h1422_0003, 4, 4);
    drive(1'b1, 32'h8022_0004, 32'h100, 0);
    drive(1'b1, 32'h0C00_0010, 0, 0);
    drive(1'b1, 32'hFC00_0000, 1, 2);
    drive(1'b1, 32'h0420_0000, 32'h8000_0000, 0);
    drive(1'b1, 32'h0421_0000, 0, 0);
    drive(1'b1, 32'h0422_0000, 0, 0);
    drive(1'b1, 32'h1800_0000, 0, 0);
    drive(1'b1, 32'h1C00_0000, 0, 0);
    for (int n = 0; n < 400; n++) rand_op(1'b1);
    for (int n = 0; n < 3; n++) rand_op(1'b0);
    for (int n = 0; n < 400; n++) rand_op(1'b1);
    for (int n = 0; n < 100 && sb.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
